edge_event_arbiter: RTL and testbench

EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

---
 rtl/edge_event_arbiter.sv | 146 ++++++++++++++
 tb/tb_edge_event_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/edge_event_arbiter.sv
// Round-robin arbiter for rising-edge events on N level inputs; one grant at a
// time to a shared resource, with per-channel pending and sticky overflow flags.
module edge_event_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   in,
    input  logic           grant_ack,
    output logic           grant_valid,
    output logic [IDW-1:0] grant_id,
    output logic [N-1:0]   pending,
    output logic [N-1:0]   overflow,
    output logic           busy
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   in_prev_q;
    logic [N-1:0]   pending_q, pending_d;
    logic [N-1:0]   overflow_q, overflow_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] grant_id_q, grant_id_d;
    logic           grant_valid_q, grant_valid_d;
    logic           busy_q, busy_d;
    logic [N-1:0]   rise_s;
    logic [N-1:0]   ack_clr_s;

    // First set request bit searching upward from start, wrapping at N-1.
    function automatic logic [IDW-1:0] rr_pick(input logic [N-1:0] req,
                                               input logic [IDW-1:0] start);
        logic [IDW-1:0] pick;
        logic [N-1:0]   sh;
        logic           found;
        int             idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(start) + k) % N;
            sh  = req >> idx;
            if (!found && sh[0]) begin
                found = 1'b1;
                pick  = IDW'(idx);
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] id);
        return IDW'((int'(id) + 1) % N);
    endfunction

    // Edge detection and the one-hot channel being acknowledged this edge.
    always_comb begin
        rise_s    = in & ~in_prev_q;
        ack_clr_s = '0;
        if (state_q == S_GRANT && grant_ack) begin
            ack_clr_s = N'(1) << grant_id_q;
        end else begin
            ack_clr_s = '0;
        end
    end

    // Event bookkeeping: a rise on the channel being acked re-arms it without overflow.
    always_comb begin
        pending_d  = (pending_q & ~ack_clr_s) | rise_s;
        overflow_d = overflow_q | (rise_s & pending_q & ~ack_clr_s);
    end

    // Arbiter FSM next-state and registered-output values.
    always_comb begin
        state_d       = state_q;
        grant_valid_d = grant_valid_q;
        grant_id_d    = grant_id_q;
        ptr_d         = ptr_q;
        busy_d        = busy_q;
        case (state_q)
            S_IDLE: begin
                if (pending_q != '0) begin
                    state_d       = S_GRANT;
                    grant_id_d    = rr_pick(pending_q, ptr_q);
                    grant_valid_d = 1'b1;
                    busy_d        = 1'b1;
                end else begin
                    state_d       = S_IDLE;
                    grant_valid_d = 1'b0;
                    busy_d        = 1'b0;
                end
            end
            S_GRANT: begin
                if (grant_ack) begin
                    state_d       = S_IDLE;
                    grant_valid_d = 1'b0;
                    busy_d        = 1'b0;
                    ptr_d         = next_ptr(grant_id_q);
                end else begin
                    state_d       = S_GRANT;
                    grant_valid_d = 1'b1;
                    busy_d        = 1'b1;
                end
            end
            default: begin
                state_d       = S_IDLE;
                grant_valid_d = 1'b0;
                busy_d        = 1'b0;
            end
        endcase
    end

    // State register; reset drops any outstanding grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            in_prev_q     <= '0;
            pending_q     <= '0;
            overflow_q    <= '0;
            ptr_q         <= '0;
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            in_prev_q     <= in;
            pending_q     <= pending_d;
            overflow_q    <= overflow_d;
            ptr_q         <= ptr_d;
            grant_id_q    <= grant_id_d;
            grant_valid_q <= grant_valid_d;
            busy_q        <= busy_d;
        end
    end

    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;
    assign pending     = pending_q;
    assign overflow    = overflow_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Self-checking bench for edge_event_arbiter: directed vector table, hand-written
// corner sequences, and randomized traffic against a behavioural model.
module tb_edge_event_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   in_s;
    logic           ack;
    logic           grant_valid;
    logic [IDW-1:0] grant_id;
    logic [N-1:0]   pending;
    logic [N-1:0]   overflow;
    logic           busy;

    int n_cmp  = 0;
    int n_fail = 0;

    edge_event_arbiter #(.N(N), .IDW(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in         (in_s),
        .grant_ack  (ack),
        .grant_valid(grant_valid),
        .grant_id   (grant_id),
        .pending    (pending),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           rst;
        logic [N-1:0]   in;
        logic           ack;
        logic           exp_valid;
        logic [IDW-1:0] exp_gid;
        logic [N-1:0]   exp_pend;
    } vec_t;

    vec_t tbl[$];

    // Behavioural model: per-channel event flags, a "who is being served" index.
    bit m_prev[N];
    bit m_pend[N];
    bit m_ovf[N];
    bit m_busy;
    int m_gid;
    int m_ptr;

    task automatic model_step(input logic r, input logic [N-1:0] i, input logic a);
        bit old_pend[N];
        bit rise;
        int acked;
        int pick;
        if (r) begin
            for (int c = 0; c < N; c++) begin
                m_prev[c] = 1'b0;
                m_pend[c] = 1'b0;
                m_ovf[c]  = 1'b0;
            end
            m_busy = 1'b0;
            m_gid  = 0;
            m_ptr  = 0;
            return;
        end
        old_pend = m_pend;
        acked    = (m_busy && a) ? m_gid : -1;
        for (int c = 0; c < N; c++) begin
            rise = i[c] && !m_prev[c];
            if (c == acked) begin
                m_pend[c] = rise;
            end else begin
                if (rise && old_pend[c]) m_ovf[c] = 1'b1;
                m_pend[c] = old_pend[c] || rise;
            end
            m_prev[c] = i[c];
        end
        if (!m_busy) begin
            pick = -1;
            for (int k = 0; k < N; k++) begin
                if (pick < 0 && old_pend[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
            end
            if (pick >= 0) begin
                m_busy = 1'b1;
                m_gid  = pick;
            end
        end else if (a) begin
            m_busy = 1'b0;
            m_ptr  = (m_gid + 1) % N;
        end
    endtask

    task automatic drive(input logic r, input logic [N-1:0] i, input logic a);
        rst  = r;
        in_s = i;
        ack  = a;
        model_step(r, i, a);
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic ev, input logic [IDW-1:0] eg,
                         input logic [N-1:0] ep, input logic [N-1:0] eo, input logic gid_chk);
        logic ok;
        n_cmp++;
        ok = (grant_valid === ev) && (busy === ev) && (pending === ep) &&
             (overflow === eo) && (!gid_chk || (grant_id === eg));
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got valid=%b busy=%b id=%0d pend=%b ovf=%b ; want valid=%b id=%0d pend=%b ovf=%b",
                     name, grant_valid, busy, grant_id, pending, overflow, ev, eg, ep, eo);
        end
    endtask

    task automatic add(input logic r, input logic [N-1:0] i, input logic a,
                       input logic ev, input logic [IDW-1:0] eg, input logic [N-1:0] ep);
        vec_t v;
        v.rst = r; v.in = i; v.ack = a;
        v.exp_valid = ev; v.exp_gid = eg; v.exp_pend = ep;
        tbl.push_back(v);
    endtask

    task automatic step_chk(input string name, input logic r, input logic [N-1:0] i, input logic a,
                            input logic ev, input logic [IDW-1:0] eg,
                            input logic [N-1:0] ep, input logic [N-1:0] eo);
        drive(r, i, a);
        check(name, ev, eg, ep, eo, ev | r);
    endtask

    logic [N-1:0] mp;
    logic [N-1:0] mo;
    logic         r_rand;

    initial begin
        rst  = 1'b1;
        in_s = '0;
        ack  = 1'b0;

        // Single event on channel 2, held level, idle ack ignored.
        add(1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000);
        add(1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000);
        add(1'b0, 4'b0100, 1'b0, 1'b0, 2'd0, 4'b0100);
        add(1'b0, 4'b0100, 1'b0, 1'b1, 2'd2, 4'b0100);
        add(1'b0, 4'b0100, 1'b0, 1'b1, 2'd2, 4'b0100);
        add(1'b0, 4'b0100, 1'b1, 1'b0, 2'd0, 4'b0000);
        add(1'b0, 4'b0100, 1'b0, 1'b0, 2'd0, 4'b0000);
        add(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000);
        add(1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000);
        // Round-robin order 0,1,3 then 0,1.
        add(1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000);
        add(1'b0, 4'b1011, 1'b0, 1'b0, 2'd0, 4'b1011);
        add(1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, 4'b1011);
        add(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b1010);
        add(1'b0, 4'b0000, 1'b0, 1'b1, 2'd1, 4'b1010);
        add(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b1000);
        add(1'b0, 4'b0000, 1'b0, 1'b1, 2'd3, 4'b1000);
        add(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000);
        add(1'b0, 4'b0011, 1'b0, 1'b0, 2'd0, 4'b0011);
        add(1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, 4'b0011);
        add(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0010);
        add(1'b0, 4'b0000, 1'b0, 1'b1, 2'd1, 4'b0010);
        add(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000);
        add(1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000);
        // Wrap: after serving 2, pending 1001 grants 3 then 0.
        add(1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000);
        add(1'b0, 4'b0100, 1'b0, 1'b0, 2'd0, 4'b0100);
        add(1'b0, 4'b0000, 1'b0, 1'b1, 2'd2, 4'b0100);
        add(1'b0, 4'b1001, 1'b1, 1'b0, 2'd0, 4'b1001);
        add(1'b0, 4'b0000, 1'b0, 1'b1, 2'd3, 4'b1001);
        add(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0001);
        add(1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, 4'b0001);
        add(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000);

        foreach (tbl[k]) begin
            drive(tbl[k].rst, tbl[k].in, tbl[k].ack);
            check($sformatf("vec%0d", k), tbl[k].exp_valid, tbl[k].exp_gid,
                  tbl[k].exp_pend, 4'b0000, tbl[k].exp_valid | tbl[k].rst);
        end

        // Overflow: channel 1 held un-acked while channel 0 rises twice.
        step_chk("ovf_rst",   1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000);
        step_chk("ovf_p1",    1'b0, 4'b0010, 1'b0, 1'b0, 2'd0, 4'b0010, 4'b0000);
        step_chk("ovf_g1",    1'b0, 4'b0000, 1'b0, 1'b1, 2'd1, 4'b0010, 4'b0000);
        step_chk("ovf_e0a",   1'b0, 4'b0001, 1'b0, 1'b1, 2'd1, 4'b0011, 4'b0000);
        step_chk("ovf_lo",    1'b0, 4'b0000, 1'b0, 1'b1, 2'd1, 4'b0011, 4'b0000);
        step_chk("ovf_e0b",   1'b0, 4'b0001, 1'b0, 1'b1, 2'd1, 4'b0011, 4'b0001);
        step_chk("ovf_ack1",  1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0001, 4'b0001);
        step_chk("ovf_g0",    1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, 4'b0001, 4'b0001);
        step_chk("ovf_ack0",  1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 4'b0001);
        step_chk("ovf_none1", 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0001);
        step_chk("ovf_none2", 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0001);

        // Rise coinciding with ack on the granted channel re-arms it.
        step_chk("co_rst",  1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000);
        step_chk("co_p2",   1'b0, 4'b0100, 1'b0, 1'b0, 2'd0, 4'b0100, 4'b0000);
        step_chk("co_g2",   1'b0, 4'b0000, 1'b0, 1'b1, 2'd2, 4'b0100, 4'b0000);
        step_chk("co_ack",  1'b0, 4'b0100, 1'b1, 1'b0, 2'd0, 4'b0100, 4'b0000);
        step_chk("co_g2b",  1'b0, 4'b0000, 1'b0, 1'b1, 2'd2, 4'b0100, 4'b0000);
        step_chk("co_done", 1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000);

        // Reset mid-grant with input held high.
        step_chk("rm_rst0", 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000);
        step_chk("rm_p3",   1'b0, 4'b1000, 1'b0, 1'b0, 2'd0, 4'b1000, 4'b0000);
        step_chk("rm_g3",   1'b0, 4'b1000, 1'b0, 1'b1, 2'd3, 4'b1000, 4'b0000);
        step_chk("rm_rst",  1'b1, 4'b1000, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000);
        step_chk("rm_p3b",  1'b0, 4'b1000, 1'b0, 1'b0, 2'd0, 4'b1000, 4'b0000);
        step_chk("rm_g3b",  1'b0, 4'b1000, 1'b0, 1'b1, 2'd3, 4'b1000, 4'b0000);

        // Randomized traffic against the behavioural model.
        drive(1'b1, 4'b0000, 1'b0);
        check("rand_rst", 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b1);
        for (int t = 0; t < 3000; t++) begin
            r_rand = ($urandom_range(0, 249) == 0);
            drive(r_rand, N'($urandom_range(0, (1 << N) - 1)), ($urandom_range(0, 2) == 0));
            for (int c = 0; c < N; c++) begin
                mp[c] = m_pend[c];
                mo[c] = m_ovf[c];
            end
            check($sformatf("rand%0d", t), m_busy, IDW'(m_gid), mp, mo, m_busy | r_rand);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
